multi_voice_wave_addr: RTL and testbench
========================================

Name: multi_voice_wave_addr

Overview:
- Per-channel sample-address generator for waveform playback from sample ROM/RAM.
- Successor to the single-voice address generator:
  - CH independent voices.
  - Parametrised address width.
  - Per-voice base address and length.
  - One-shot or loop mode.
  - Sample-rate tick gating.
  - Retrigger, explicit stop and a done pulse.
- Sits between the pad/note decoder (triggers) and the sample memory read ports / mixer.

Parameters:
- CH, 4, number of independent voices.
- AW, 15, sample address width in bits.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all voices.
- trigger  in  CH  per-voice start/retrigger request, sampled at rising edge.
- stop  in  CH  per-voice abort request, sampled at rising edge.
- loop_mode  in  CH  per-voice mode, captured at trigger: 1 = loop, 0 = one-shot.
- base  in  CH*AW  per-voice start address; voice i uses bits [i*AW +: AW]; captured at trigger.
- length  in  CH*AW  per-voice last offset (inclusive; length+1 samples); captured at trigger.
- tick  in  1  sample-rate strobe shared by all voices; one-cycle pulse.
- address  out  CH*AW  registered per-voice read address; voice i at [i*AW +: AW].
- playing  out  CH  per-voice active flag.
- done  out  CH  one-cycle pulse when a one-shot voice finishes naturally.

Behaviour:
- Reset:
  - All voices go to IDLE.
  - address, playing, done, latched base/length/mode and offset counters all 0.
  - Takes effect immediately (asynchronous); release is clean on the next edge.
- Per-voice FSM, two states: IDLE and PLAY.
- Priority per voice at each edge: stop > trigger > tick.
- IDLE:
  - Outputs: address = 0, playing = 0.
  - trigger=1 (and stop=0):
    - Latch base, length, loop_mode; offset = 0.
    - Next cycle: address = base, playing = 1, state PLAY.
  - Latency is 1 edge. The first sample is presented before any tick; tick is ignored on the trigger edge.
- PLAY:
  - stop=1:
    - Go to IDLE; address = 0, playing = 0.
    - done is not pulsed.
  - trigger=1 (retrigger):
    - Re-latch base, length, loop_mode; offset = 0; address = new base.
    - Stay in PLAY; done is not pulsed.
  - tick=1 and offset < length_latched:
    - offset += 1.
    - address = base_latched + offset (new value), mod 2^AW. Address wraps silently past all-ones.
  - tick=1 and offset == length_latched:
    - loop=1: offset = 0, address = base_latched, stay in PLAY; done not pulsed.
    - loop=0: go to IDLE; address = 0, playing = 0; done = 1 for exactly that next cycle.
  - tick=0: hold all state.
- length = 0 plays a single sample:
  - Present for one tick period.
  - Then ends (one-shot) or repeats base (loop).
- Input changes to base/length/loop_mode during PLAY have no effect until the next trigger.
- Voices are fully independent; simultaneous events on different voices are all honoured in the same cycle.
- done is never asserted while playing is 1 for that voice in the same cycle.
- Offset counter is AW bits. length is compared unsigned.
- No combinational path from inputs to outputs.

Test Plan:
- Reset and start (CH=4, AW=15):
  - Assert reset mid-cycle → all outputs 0 without waiting for an edge.
  - Release reset, pulse trigger[0] with base0=100, length0=3, loop=0 → next cycle playing[0]=1, address0=100.
  - Ticks every 4 cycles → address0 100,101,102,103.
  - After the 4th tick → playing[0]=0, address0=0, done[0]=1 for one cycle.
- Loop and stop:
  - Voice 1 with base=8, length=1, loop=1, 6 ticks → address1 sequence 8,9,8,9,8,9,8; done[1] never asserted.
  - stop[1] → IDLE next cycle, no done.
- Retrigger:
  - Voice 2 playing base=50, length=10, at offset 5: trigger[2] with base=200 → next cycle address2=200, playing stays 1.
  - Then 200..210 over 10 ticks.
- Priority collision:
  - Same edge stop[3]=trigger[3]=tick=1 while voice 3 playing → IDLE, no done.
  - In IDLE, trigger with tick → address=base, no advance.
- Wrap and single-sample:
  - base=32766, length=3 → addresses 32766, 32767, 0, 1, then done.
  - base=5, length=0, loop=0 → address 5 for one tick period, then done.
- Concurrency:
  - Trigger all 4 voices on the same edge with distinct bases/lengths → each voice follows its own sequence.
  - Each voice's done is asserted independently at the correct tick.

Source files
------------

// File: rtl/multi_voice_wave_addr.sv
// ============================================================================
// multi_voice_wave_addr
// ----------------------------------------------------------------------------
// Per-voice sample-address generator for waveform playback out of a sample
// ROM/RAM. Each of the CH voices is an independent two-state machine
// (IDLE / PLAY). A trigger latches that voice's base address, last offset and
// loop mode, then walks the read address from base to base+length, advancing
// once per shared sample-rate tick. At the end a voice either wraps back to
// base (loop mode) or returns to IDLE and pulses done (one-shot mode).
//
// Ports
//   clock      in   1      system clock, all state changes on the rising edge
//   reset      in   1      asynchronous active-high reset, clears all voices
//   trigger    in   CH     per-voice start / retrigger request
//   stop       in   CH     per-voice abort request (beats trigger and tick)
//   loop_mode  in   CH     per-voice mode captured at trigger, 1 = loop
//   base       in   CH*AW  per-voice start address, voice i at [i*AW +: AW]
//   length     in   CH*AW  per-voice last offset (inclusive), same packing
//   tick       in   1      shared sample-rate strobe, one-cycle pulse
//   address    out  CH*AW  registered per-voice read address
//   playing    out  CH     per-voice active flag
//   done       out  CH     one-cycle pulse when a one-shot voice ends naturally
//
// Every output comes straight from a register, so there is no combinational
// path from any input to any output.
// ============================================================================
module multi_voice_wave_addr #(
    parameter int CH = 4,
    parameter int AW = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CH-1:0]    trigger,
    input  logic [CH-1:0]    stop,
    input  logic [CH-1:0]    loop_mode,
    input  logic [CH*AW-1:0] base,
    input  logic [CH*AW-1:0] length,
    input  logic             tick,
    output logic [CH*AW-1:0] address,
    output logic [CH-1:0]    playing,
    output logic [CH-1:0]    done
);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } voiceState_t;

    localparam logic [AW-1:0] ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] ZERO = '0;

    voiceState_t   state_q      [CH];
    voiceState_t   state_d      [CH];
    logic [AW-1:0] baseLatch_q  [CH];
    logic [AW-1:0] baseLatch_d  [CH];
    logic [AW-1:0] lenLatch_q   [CH];
    logic [AW-1:0] lenLatch_d   [CH];
    logic [AW-1:0] offset_q     [CH];
    logic [AW-1:0] offset_d     [CH];
    logic [AW-1:0] address_q    [CH];
    logic [AW-1:0] address_d    [CH];
    logic [CH-1:0] loopLatch_q;
    logic [CH-1:0] loopLatch_d;
    logic [CH-1:0] done_q;
    logic [CH-1:0] done_d;

    // State register for every voice. The address is kept as its own register
    // (rather than base+offset computed on the output) so the memory read port
    // sees a clean flop output and IDLE can force it to zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CH; i++) begin
                state_q[i]     <= IDLE;
                baseLatch_q[i] <= ZERO;
                lenLatch_q[i]  <= ZERO;
                offset_q[i]    <= ZERO;
                address_q[i]   <= ZERO;
            end
            loopLatch_q <= '0;
            done_q      <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                state_q[i]     <= state_d[i];
                baseLatch_q[i] <= baseLatch_d[i];
                lenLatch_q[i]  <= lenLatch_d[i];
                offset_q[i]    <= offset_d[i];
                address_q[i]   <= address_d[i];
            end
            loopLatch_q <= loopLatch_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic, evaluated independently for each voice. Priority is
    // stop, then trigger, then tick. A trigger on its own edge ignores tick so
    // the first sample (base) is always presented for a full tick period.
    // done defaults low so it can only ever be a single-cycle pulse, and it is
    // only raised on the transition into IDLE, so it never overlaps playing.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            state_d[i]     = state_q[i];
            baseLatch_d[i] = baseLatch_q[i];
            lenLatch_d[i]  = lenLatch_q[i];
            offset_d[i]    = offset_q[i];
            address_d[i]   = address_q[i];
            loopLatch_d[i] = loopLatch_q[i];
            done_d[i]      = 1'b0;

            if (stop[i]) begin
                state_d[i]   = IDLE;
                offset_d[i]  = ZERO;
                address_d[i] = ZERO;
            end else if (trigger[i]) begin
                state_d[i]     = PLAY;
                baseLatch_d[i] = base[i*AW +: AW];
                lenLatch_d[i]  = length[i*AW +: AW];
                loopLatch_d[i] = loop_mode[i];
                offset_d[i]    = ZERO;
                address_d[i]   = base[i*AW +: AW];
            end else if ((state_q[i] == PLAY) && tick) begin
                if (offset_q[i] < lenLatch_q[i]) begin
                    // Address arithmetic is modulo 2^AW, so a run that
                    // crosses all-ones simply continues from zero.
                    offset_d[i]  = offset_q[i] + ONE;
                    address_d[i] = baseLatch_q[i] + offset_q[i] + ONE;
                end else if (loopLatch_q[i]) begin
                    offset_d[i]  = ZERO;
                    address_d[i] = baseLatch_q[i];
                end else begin
                    state_d[i]   = IDLE;
                    offset_d[i]  = ZERO;
                    address_d[i] = ZERO;
                    done_d[i]    = 1'b1;
                end
            end
        end
    end

    // Pack the per-voice registers onto the flat output buses.
    for (genvar g = 0; g < CH; g++) begin : gOut
        assign address[g*AW +: AW] = address_q[g];
        assign playing[g]          = (state_q[g] == PLAY);
    end

    assign done = done_q;

endmodule

// File: tb/tb_multi_voice_wave_addr.sv
// ============================================================================
// tb_multi_voice_wave_addr
// ----------------------------------------------------------------------------
// Self-checking bench for multi_voice_wave_addr with CH=4, AW=15. Most
// scenarios are single-voice cycle tables: each row holds the inputs for one
// rising edge and the address/playing/done expected on that voice just after
// it. Asynchronous reset and four-voice concurrency are written out by hand.
// ============================================================================
module tb_multi_voice_wave_addr;

    localparam int CH = 4;
    localparam int AW = 15;

    typedef struct {
        int          voice;
        logic        trig;
        logic        stp;
        logic        tk;
        logic        lp;
        logic [14:0] b;
        logic [14:0] l;
        logic [14:0] eAddr;
        logic        ePlay;
        logic        eDone;
        string       name;
    } vec_t;

    logic             clock;
    logic             reset;
    logic [CH-1:0]    trigger;
    logic [CH-1:0]    stop;
    logic [CH-1:0]    loop_mode;
    logic [CH*AW-1:0] base;
    logic [CH*AW-1:0] length;
    logic             tick;
    logic [CH*AW-1:0] address;
    logic [CH-1:0]    playing;
    logic [CH-1:0]    done;

    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];

    multi_voice_wave_addr #(.CH(CH), .AW(AW)) dut (
        .clock     (clock),
        .reset     (reset),
        .trigger   (trigger),
        .stop      (stop),
        .loop_mode (loop_mode),
        .base      (base),
        .length    (length),
        .tick      (tick),
        .address   (address),
        .playing   (playing),
        .done      (done)
    );

    // 10-unit clock period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Watchdog so the run always terminates even if the clock stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    // Drive one voice's inputs with everything else idle.
    task automatic applyStimulus(input vec_t v);
        trigger   = '0;
        stop      = '0;
        loop_mode = '0;
        base      = '0;
        length    = '0;
        tick      = v.tk;
        trigger[v.voice]           = v.trig;
        stop[v.voice]              = v.stp;
        loop_mode[v.voice]         = v.lp;
        base[v.voice*AW +: AW]     = v.b;
        length[v.voice*AW +: AW]   = v.l;
    endtask

    task automatic addVec(input int vc, input logic trig, input logic stp, input logic tk,
                          input logic lp, input logic [14:0] b, input logic [14:0] l,
                          input logic [14:0] eA, input logic eP, input logic eD, input string nm);
        vec_t v;
        v.voice = vc; v.trig = trig; v.stp = stp; v.tk = tk; v.lp = lp;
        v.b = b; v.l = l; v.eAddr = eA; v.ePlay = eP; v.eDone = eD; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic clearInputs();
        trigger = '0; stop = '0; loop_mode = '0; base = '0; length = '0; tick = 1'b0;
    endtask

    // Four-voice concurrency expectations: row 0 is the trigger edge, rows
    // 1..4 are successive tick edges.
    logic [14:0] ccAddr [5][4];
    logic [3:0]  ccPlay [5];
    logic [3:0]  ccDone [5];

    initial begin
        // One-shot base=100 length=3; base/length changes mid-play are ignored.
        addVec(0, 1, 0, 0, 0, 100, 3, 100, 1, 0, "v0 trigger");
        addVec(0, 0, 0, 0, 0, 999, 0, 100, 1, 0, "v0 hold");
        addVec(0, 0, 0, 1, 0, 999, 0, 101, 1, 0, "v0 tick1");
        addVec(0, 0, 0, 0, 1, 999, 0, 101, 1, 0, "v0 hold");
        addVec(0, 0, 0, 1, 0, 999, 0, 102, 1, 0, "v0 tick2");
        addVec(0, 0, 0, 1, 0, 999, 0, 103, 1, 0, "v0 tick3");
        addVec(0, 0, 0, 0, 0, 999, 0, 103, 1, 0, "v0 hold");
        addVec(0, 0, 0, 1, 0, 999, 0,   0, 0, 1, "v0 end");
        addVec(0, 0, 0, 0, 0,   0, 0,   0, 0, 0, "v0 done gone");
        // Loop base=8 length=1, six ticks, then stop.
        addVec(1, 1, 0, 0, 1, 8, 1, 8, 1, 0, "v1 trigger");
        for (int k = 1; k <= 6; k++)
            addVec(1, 0, 0, 1, 0, 0, 0, (k % 2 == 1) ? 15'd9 : 15'd8, 1, 0, "v1 loop tick");
        addVec(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, "v1 stop");
        addVec(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, "v1 idle tick");
        // Retrigger at offset 5.
        addVec(2, 1, 0, 0, 0, 50, 10, 50, 1, 0, "v2 trigger");
        for (int k = 1; k <= 5; k++)
            addVec(2, 0, 0, 1, 0, 0, 0, 15'(50 + k), 1, 0, "v2 tick");
        addVec(2, 1, 0, 1, 0, 200, 10, 200, 1, 0, "v2 retrigger");
        for (int k = 1; k <= 10; k++)
            addVec(2, 0, 0, 1, 0, 0, 0, 15'(200 + k), 1, 0, "v2 tick after retrig");
        addVec(2, 0, 0, 1, 0, 0, 0, 0, 0, 1, "v2 end");
        // Priority: stop+trigger+tick while playing, then trigger+tick in IDLE.
        addVec(3, 1, 0, 0, 0, 300, 5, 300, 1, 0, "v3 trigger");
        addVec(3, 0, 0, 1, 0,   0, 0, 301, 1, 0, "v3 tick");
        addVec(3, 1, 1, 1, 0, 777, 5,   0, 0, 0, "v3 stop wins");
        addVec(3, 1, 0, 1, 0, 400, 5, 400, 1, 0, "v3 trig ignores tick");
        addVec(3, 0, 0, 1, 0,   0, 0, 401, 1, 0, "v3 tick");
        addVec(3, 0, 1, 0, 0,   0, 0,   0, 0, 0, "v3 stop");
        // Wrap past all-ones.
        addVec(0, 1, 0, 0, 0, 32766, 3, 32766, 1, 0, "wrap trigger");
        addVec(0, 0, 0, 1, 0,     0, 0, 32767, 1, 0, "wrap tick1");
        addVec(0, 0, 0, 1, 0,     0, 0,     0, 1, 0, "wrap tick2");
        addVec(0, 0, 0, 1, 0,     0, 0,     1, 1, 0, "wrap tick3");
        addVec(0, 0, 0, 1, 0,     0, 0,     0, 0, 1, "wrap end");
        // Single sample, one-shot and loop.
        addVec(0, 1, 0, 0, 0, 5, 0, 5, 1, 0, "len0 trigger");
        addVec(0, 0, 0, 0, 0, 0, 0, 5, 1, 0, "len0 hold");
        addVec(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, "len0 end");
        addVec(1, 1, 0, 0, 1, 7, 0, 7, 1, 0, "len0 loop trigger");
        addVec(1, 0, 0, 1, 0, 0, 0, 7, 1, 0, "len0 loop tick1");
        addVec(1, 0, 0, 1, 0, 0, 0, 7, 1, 0, "len0 loop tick2");
        addVec(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, "len0 loop stop");

        ccAddr[0] = '{15'd1000, 15'd2000, 15'd3000, 15'd4000};
        ccAddr[1] = '{15'd0,    15'd2001, 15'd3001, 15'd4001};
        ccAddr[2] = '{15'd0,    15'd0,    15'd3002, 15'd4002};
        ccAddr[3] = '{15'd0,    15'd0,    15'd0,    15'd4003};
        ccAddr[4] = '{15'd0,    15'd0,    15'd0,    15'd0};
        ccPlay    = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        ccDone    = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

        // Asynchronous reset: outputs clear without any clock edge.
        clearInputs();
        reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkOutput("reset address", 32'(address == '0), 1);
        checkOutput("reset playing", 32'(playing), 0);
        checkOutput("reset done", 32'(done), 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Table-driven single-voice scenarios.
        foreach (vecs[n]) begin
            @(negedge clock);
            applyStimulus(vecs[n]);
            @(posedge clock);
            #1;
            checkOutput({vecs[n].name, " address"},
                        32'(address[vecs[n].voice*AW +: AW]), 32'(vecs[n].eAddr));
            checkOutput({vecs[n].name, " playing"}, 32'(playing[vecs[n].voice]), 32'(vecs[n].ePlay));
            checkOutput({vecs[n].name, " done"}, 32'(done[vecs[n].voice]), 32'(vecs[n].eDone));
        end

        // Mid-cycle reset while a voice is playing.
        @(negedge clock);
        clearInputs();
        trigger[0] = 1'b1;
        base[0 +: AW] = 15'd77;
        length[0 +: AW] = 15'd5;
        @(posedge clock);
        #1;
        checkOutput("pre-reset address", 32'(address[0 +: AW]), 77);
        checkOutput("pre-reset playing", 32'(playing[0]), 1);
        @(negedge clock);
        clearInputs();
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset address", 32'(address == '0), 1);
        checkOutput("async reset playing", 32'(playing), 0);
        @(negedge clock);
        reset = 1'b0;
        tick = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("post-reset address", 32'(address == '0), 1);
        checkOutput("post-reset playing", 32'(playing), 0);

        // All four voices triggered on the same edge with distinct lengths.
        @(negedge clock);
        clearInputs();
        trigger = 4'hF;
        for (int v = 0; v < CH; v++) begin
            base[v*AW +: AW]   = 15'((v + 1) * 1000);
            length[v*AW +: AW] = 15'(v);
        end
        for (int s = 0; s < 5; s++) begin
            if (s > 0) begin
                // Quiet cycle between ticks: nothing moves and no done.
                @(negedge clock);
                clearInputs();
                @(posedge clock);
                #1;
                checkOutput($sformatf("cc gap%0d done", s), 32'(done), 0);
                @(negedge clock);
                tick = 1'b1;
            end
            @(posedge clock);
            #1;
            for (int v = 0; v < CH; v++)
                checkOutput($sformatf("cc step%0d v%0d address", s, v),
                            32'(address[v*AW +: AW]), 32'(ccAddr[s][v]));
            checkOutput($sformatf("cc step%0d playing", s), 32'(playing), 32'(ccPlay[s]));
            checkOutput($sformatf("cc step%0d done", s), 32'(done), 32'(ccDone[s]));
        end

        @(negedge clock);
        clearInputs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
